boreal_dbg_spi_slave: RTL and testbench
=======================================

Name: boreal_dbg_spi_slave

Overview:
SPI slave debug port that lets an external MCU read the Boreal status register file.
- Decodes an 8-bit read command from the MCU.
- Issues a single-cycle read strobe and address to the register file.
- Captures the registered 16-bit result and shifts it back on MISO.
- Counts completed transactions; the count is fed back into the register file as spi_txn_count.

Sits on the clk domain boundary: SPI pins are asynchronous inputs, oversampled by clk.

Parameters:
SYNC_STAGES, 2, synchronizer depth for spi_sclk/spi_cs_n/spi_mosi (legal 2..3)
CNT_WIDTH, 16, width of transaction counter (top zero-extends to 16 if smaller)
BAD_WORD, 16'hBAD0, word shifted out for an invalid command

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
spi_sclk  in  1  SPI clock from MCU, mode 0 (CPOL=0, CPHA=0), asynchronous
spi_cs_n  in  1  SPI chip select, active low, asynchronous
spi_mosi  in  1  SPI data in, MSB first
spi_miso  out  1  SPI data out, MSB first
spi_miso_oe  out  1  MISO output enable (1 while frame active)
reg_addr  out  3  register select to status register file
reg_rd_en  out  1  single-cycle read strobe to status register file
reg_rd_data  in  16  registered read data, valid 1 clk after reg_rd_en
spi_txn_count  out  CNT_WIDTH  count of completed valid read frames
frame_err  out  1  sticky: aborted frame or invalid command seen
err_clr  in  1  synchronous clear of frame_err

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; synchronizers loaded with 1 (cs_n), 0 (sclk, mosi).
- Synchronization and edge detection:
  - All SPI inputs pass SYNC_STAGES flops.
  - Edges are detected on the synchronized sclk with a further history flop.
- Timing constraint: SCLK half-period >= 8 clk cycles; the bench must respect it.
- Frame format, CS low, 24 SCLK cycles:
  - Byte 0 = command: bit7 = 1 (read), bits6:3 = 0, bits2:0 = addr.
  - Bits 8..23: 16-bit data on MISO.
- MOSI is sampled on synced SCLK rising edges. MISO changes on synced SCLK falling edges. MISO = 0 during the command byte.
- spi_miso_oe = ~cs_n_sync.
- FSM states: IDLE, CMD, ISSUE, CAPTURE, DATA, TAIL.
  - IDLE: wait for synced cs_n falling; clear bit counter -> CMD.
  - CMD: shift 8 MOSI bits; on 8th rising edge -> ISSUE.
  - ISSUE, valid command: reg_rd_en = 1 for exactly one clk with reg_addr = cmd[2:0] -> CAPTURE.
  - ISSUE, invalid command (bit7 = 0 or bits6:3 != 0): no strobe; set bad flag -> CAPTURE.
  - CAPTURE (next clk): load shift-out register with reg_rd_data, or BAD_WORD if bad -> DATA.
  - DATA: on each synced SCLK falling edge, drive next bit MSB first. The first falling edge after the command drives bit15.
  - DATA exit: after the 16th bit is sampled by the master (24th rising edge) -> TAIL.
  - TAIL: MISO = 0; extra SCLK edges are ignored; wait for cs_n rising.
- Frame end (synced cs_n rising), in any non-IDLE state:
  - TAIL and not bad: spi_txn_count += 1, wrapping modulo 2^CNT_WIDTH.
  - TAIL and bad: frame_err <= 1; count unchanged.
  - Any other state (abort, <24 bits): frame_err <= 1; count unchanged; no further reg_rd_en.
  - All cases -> IDLE.
- reg_addr holds its last value between strobes. reg_rd_en never asserts outside ISSUE.
- err_clr:
  - Clears frame_err next cycle.
  - If err_clr and a new error are in the same cycle, the error wins (frame_err = 1).
- Reset mid-frame:
  - Immediate return to IDLE, counter 0, frame_err 0.
  - If cs_n is still low when reset releases, that frame is ignored until cs_n goes high (no CMD entry).

Decomposition:
- Shared package boreal_dbg_pkg holds:
  - FSM state enum.
  - Command field constants: CMD_READ_BIT = 7, CMD_ADDR_MSB = 2.
  - FRAME_BITS = 24.
  - BAD_WORD default.
- One natural sub-module: boreal_sync_edge. It is a SYNC_STAGES synchronizer plus rise/fall pulse generator, instantiated for sclk and cs_n. MOSI uses the plain synchronizer path.

Test Plan:
- Read addr 1: cmd 0x81, model returns 16'h1234 -> one reg_rd_en with reg_addr = 1; MISO bits 8..23 = 0x1234; spi_txn_count 0 -> 1; frame_err = 0.
- Invalid cmd 0x41 -> no reg_rd_en; MISO = 0xBAD0; frame_err = 1; count unchanged. Then pulse err_clr -> frame_err = 0.
- Abort: cs_n high after 12 SCLK cycles of cmd 0x80 -> frame_err = 1; count unchanged. Next full frame to addr 2 returns correct status bits and count increments.
- Wrap: CNT_WIDTH = 4, 17 valid back-to-back frames (CS high 4 clk between) -> count sequence 1..15, 0, 1.
- Reset mid-frame: assert rst_n low at bit 10 of a frame -> outputs 0. The remainder of that frame, with cs_n still low, produces no reg_rd_en and no count. The following clean frame works.
- Overlength: 30 SCLK cycles with cmd 0x84 -> MISO = data then 0 for bits 24..29; count += 1; frame_err = 0.

Source files
------------

// File: rtl/boreal_dbg_pkg.sv
// Shared definitions for the Boreal debug SPI slave: FSM states, command
// field positions, frame length and the default invalid-command word.
package boreal_dbg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StIssue,
        StCapture,
        StData,
        StTail
    } state_e;

    // Command byte layout: bit7 = read, bits6:3 must be zero, bits2:0 = addr
    localparam int unsigned CMD_READ_BIT = 7;
    localparam int unsigned CMD_ADDR_MSB = 2;
    localparam int unsigned CMD_BITS     = 8;

    // SCLK cycles in a complete read frame (command byte + 16 data bits)
    localparam int unsigned FRAME_BITS   = 24;

    localparam logic [15:0] BAD_WORD_DEFAULT = 16'hBAD0;

    // A command is a legal read only with the read bit set and reserved bits clear
    function automatic logic cmd_is_valid(input logic [7:0] cmd);
        return cmd[CMD_READ_BIT] && (cmd[CMD_READ_BIT-1:CMD_ADDR_MSB+1] == '0);
    endfunction

endpackage

// File: rtl/boreal_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, plus single-cycle rise and
// fall pulses derived from the synchronized value and one history flop.
module boreal_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the raw pin through the synchronizer chain and keep one bit of history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~hist_q;
    assign fall_o = ~sync_o & hist_q;

endmodule

// File: rtl/boreal_dbg_spi_slave.sv
// SPI mode-0 slave debug port. The MCU sends a read command byte, the block
// strobes the status register file once, then shifts the 16-bit result back
// on MISO. Completed valid frames are counted; aborted or invalid frames set
// a sticky error flag. All SPI pins are oversampled by clk.
module boreal_dbg_spi_slave
    import boreal_dbg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter logic [15:0] BAD_WORD    = BAD_WORD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic [2:0]           reg_addr,
    output logic                 reg_rd_en,
    input  logic [15:0]          reg_rd_data,
    output logic [CNT_WIDTH-1:0] spi_txn_count,
    output logic                 frame_err,
    input  logic                 err_clr
);

    // cs_n must be seen high this many cycles before a falling edge starts a
    // frame; covers the synchronizer's reset-to-1 preload so a frame already
    // in progress when reset releases is ignored until cs_n returns high.
    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;

    logic sclk_sync_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_n_sync;
    logic cs_rise;
    logic cs_fall;

    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_sync;

    logic [2:0]           arm_cnt_q;
    logic                 armed;

    state_e               state_q;
    logic [4:0]           bit_cnt_q;
    logic [7:0]           cmd_q;
    logic [7:0]           cmd_next;
    logic                 cmd_valid;
    logic [15:0]          shift_q;
    logic                 bad_q;
    logic                 miso_q;
    logic                 rd_en_q;
    logic [2:0]           addr_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 err_q;

    boreal_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (spi_sclk),
        .sync_o (sclk_sync_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    boreal_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (spi_cs_n),
        .sync_o (cs_n_sync),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // MOSI only needs the plain synchronizer; it stays aligned with synced SCLK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

    // Count consecutive cycles of synced cs_n high, saturating at ARM_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_q <= '0;
        end else if (!cs_n_sync) begin
            arm_cnt_q <= '0;
        end else if (arm_cnt_q != 3'(ARM_CYCLES)) begin
            arm_cnt_q <= arm_cnt_q + 3'd1;
        end
    end

    assign armed     = (arm_cnt_q == 3'(ARM_CYCLES));
    assign cmd_next  = {cmd_q[6:0], mosi_sync};
    assign cmd_valid = cmd_is_valid(cmd_next);

    // Frame FSM; all outputs registered. The read strobe is raised on entry to
    // StIssue so the registered read data is valid during StCapture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            cmd_q     <= '0;
            shift_q   <= '0;
            bad_q     <= 1'b0;
            miso_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            // A new error assigned below overrides this clear
            if (err_clr) begin
                err_q <= 1'b0;
            end

            if (state_q != StIdle && cs_rise) begin
                if (state_q == StTail && !bad_q) begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end else begin
                    err_q <= 1'b1;
                end
                miso_q  <= 1'b0;
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        miso_q <= 1'b0;
                        if (cs_fall && armed) begin
                            bit_cnt_q <= '0;
                            cmd_q     <= '0;
                            bad_q     <= 1'b0;
                            state_q   <= StCmd;
                        end
                    end
                    StCmd: begin
                        if (sclk_rise) begin
                            cmd_q     <= cmd_next;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
                                bad_q   <= ~cmd_valid;
                                state_q <= StIssue;
                                if (cmd_valid) begin
                                    rd_en_q <= 1'b1;
                                    addr_q  <= cmd_next[CMD_ADDR_MSB:0];
                                end
                            end
                        end
                    end
                    StIssue: begin
                        state_q <= StCapture;
                    end
                    StCapture: begin
                        shift_q <= bad_q ? BAD_WORD : reg_rd_data;
                        state_q <= StData;
                    end
                    StData: begin
                        if (sclk_fall) begin
                            miso_q  <= shift_q[15];
                            shift_q <= {shift_q[14:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
                                miso_q  <= 1'b0;
                                state_q <= StTail;
                            end
                        end
                    end
                    StTail: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign spi_miso      = miso_q;
    assign spi_miso_oe   = ~cs_n_sync;
    assign reg_addr      = addr_q;
    assign reg_rd_en     = rd_en_q;
    assign spi_txn_count = cnt_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_boreal_dbg_spi_slave.sv
// Directed bench for the Boreal debug SPI slave. A behavioural register file
// answers reads; expected MISO words go into a scoreboard queue as each frame
// is launched and are popped when the captured frame is compared.
module tb_boreal_dbg_spi_slave;

    localparam int HALF = 10;   // SCLK half-period in clk cycles

    logic        clk;
    logic        rst_n;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [2:0]  reg_addr;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data = '0;
    logic [3:0]  spi_txn_count;
    logic        frame_err;
    logic        err_clr;

    int n_vec = 0;
    int n_err = 0;

    int          rd_strobes   = 0;
    int          rd_long      = 0;
    logic        rd_prev      = 1'b0;
    logic [2:0]  rd_addr_last = '0;
    int          rd_after_rst = 0;

    logic [31:0] exp_q[$];
    logic [31:0] rx;
    int          s0;

    boreal_dbg_spi_slave #(
        .SYNC_STAGES (2),
        .CNT_WIDTH   (4),
        .BAD_WORD    (16'hBAD0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .reg_addr      (reg_addr),
        .reg_rd_en     (reg_rd_en),
        .reg_rd_data   (reg_rd_data),
        .spi_txn_count (spi_txn_count),
        .frame_err     (frame_err),
        .err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] reg_val(input logic [2:0] a);
        case (a)
            3'd0:    return 16'hC0DE;
            3'd1:    return 16'h1234;
            3'd2:    return 16'hA5C3;
            3'd3:    return 16'h5A5A;
            3'd4:    return 16'h0F0F;
            3'd5:    return 16'h8001;
            3'd6:    return 16'hFFFF;
            default: return 16'h7E81;
        endcase
    endfunction

    // Status register file model: data registered one clk after the strobe
    always_ff @(posedge clk) begin
        rd_prev <= reg_rd_en;
        if (reg_rd_en) begin
            reg_rd_data  <= reg_val(reg_addr);
            rd_strobes   <= rd_strobes + 1;
            rd_addr_last <= reg_addr;
        end
        if (reg_rd_en && rd_prev) begin
            rd_long <= rd_long + 1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One CS-low frame of nbits SCLK cycles; MISO sampled at each SCLK rise.
    // rst_at >= 0 pulses rst_n before that rising edge.
    task automatic spi_frame(input logic [7:0] cmd, input int nbits, input int rst_at,
                             output logic [31:0] rx_o);
        rx_o = '0;
        spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 8) ? cmd[7-i] : 1'b0;
            wait_clk(HALF);
            if (i == 1 && rst_at < 0) chk("oe_active", 32'(spi_miso_oe), 32'd1);
            if (i == rst_at) begin
                rst_n = 1'b0;
                wait_clk(3);
                chk("rst_mid_miso", 32'(spi_miso), 32'd0);
                chk("rst_mid_oe", 32'(spi_miso_oe), 32'd0);
                chk("rst_mid_rd_en", 32'(reg_rd_en), 32'd0);
                chk("rst_mid_addr", 32'(reg_addr), 32'd0);
                chk("rst_mid_count", 32'(spi_txn_count), 32'd0);
                chk("rst_mid_err", 32'(frame_err), 32'd0);
                rst_n = 1'b1;
                wait_clk(2);
                rd_after_rst = rd_strobes;
            end
            spi_sclk = 1'b1;
            rx_o = {rx_o[30:0], spi_miso};
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(4);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
    endtask

    initial begin
        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        err_clr  = 1'b0;
        wait_clk(3);
        chk("reset_miso", 32'(spi_miso), 32'd0);
        chk("reset_oe", 32'(spi_miso_oe), 32'd0);
        chk("reset_addr", 32'(reg_addr), 32'd0);
        chk("reset_rd_en", 32'(reg_rd_en), 32'd0);
        chk("reset_count", 32'(spi_txn_count), 32'd0);
        chk("reset_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        wait_clk(6);

        // Valid read of address 1
        s0 = rd_strobes;
        exp_q.push_back(32'(reg_val(3'd1)));
        spi_frame(8'h81, 24, -1, rx);
        chk("read_a1_miso", rx, exp_q.pop_front());
        chk("read_a1_strobes", 32'(rd_strobes - s0), 32'd1);
        chk("read_a1_addr", 32'(rd_addr_last), 32'd1);
        chk("read_a1_count", 32'(spi_txn_count), 32'd1);
        chk("read_a1_err", 32'(frame_err), 32'd0);
        chk("idle_oe", 32'(spi_miso_oe), 32'd0);

        // Invalid command: reserved bit set, read bit clear
        s0 = rd_strobes;
        exp_q.push_back(32'h0000_BAD0);
        spi_frame(8'h41, 24, -1, rx);
        chk("invalid_miso", rx, exp_q.pop_front());
        chk("invalid_strobes", 32'(rd_strobes - s0), 32'd0);
        chk("invalid_err", 32'(frame_err), 32'd1);
        chk("invalid_count", 32'(spi_txn_count), 32'd1);
        pulse_err_clr();
        chk("err_clr", 32'(frame_err), 32'd0);

        // Abort after 12 SCLK cycles of a valid command to address 0
        s0 = rd_strobes;
        exp_q.push_back(32'(reg_val(3'd0) >> 12));
        spi_frame(8'h80, 12, -1, rx);
        chk("abort_miso", rx, exp_q.pop_front());
        chk("abort_strobes", 32'(rd_strobes - s0), 32'd1);
        chk("abort_err", 32'(frame_err), 32'd1);
        chk("abort_count", 32'(spi_txn_count), 32'd1);
        pulse_err_clr();

        s0 = rd_strobes;
        exp_q.push_back(32'(reg_val(3'd2)));
        spi_frame(8'h82, 24, -1, rx);
        chk("read_a2_miso", rx, exp_q.pop_front());
        chk("read_a2_strobes", 32'(rd_strobes - s0), 32'd1);
        chk("read_a2_addr", 32'(rd_addr_last), 32'd2);
        chk("read_a2_count", 32'(spi_txn_count), 32'd2);
        chk("read_a2_err", 32'(frame_err), 32'd0);

        // Overlength frame: extra bits must read back as 0
        exp_q.push_back(32'(reg_val(3'd4)) << 6);
        spi_frame(8'h84, 30, -1, rx);
        chk("overlen_miso", rx, exp_q.pop_front());
        chk("overlen_count", 32'(spi_txn_count), 32'd3);
        chk("overlen_err", 32'(frame_err), 32'd0);

        // Reset at bit 10; rest of the frame must be ignored
        spi_frame(8'h83, 24, 10, rx);
        chk("post_rst_strobes", 32'(rd_strobes - rd_after_rst), 32'd0);
        chk("post_rst_count", 32'(spi_txn_count), 32'd0);
        chk("post_rst_err", 32'(frame_err), 32'd0);

        exp_q.push_back(32'(reg_val(3'd5)));
        spi_frame(8'h85, 24, -1, rx);
        chk("clean_miso", rx, exp_q.pop_front());
        chk("clean_count", 32'(spi_txn_count), 32'd1);

        // Counter wrap with a 4-bit counter
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(6);
        for (int k = 0; k < 17; k++) begin
            logic [2:0] a;
            a = 3'(k);
            exp_q.push_back(32'(reg_val(a)));
            spi_frame({5'b10000, a}, 24, -1, rx);
            chk("wrap_miso", rx, exp_q.pop_front());
            chk("wrap_count", 32'(spi_txn_count), 32'((k + 1) % 16));
        end
        chk("wrap_err", 32'(frame_err), 32'd0);
        chk("strobe_width", 32'(rd_long), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
